// File: rtl/btb_if.sv
// Fetch-side lookup and resolution-side training bundle for the branch target buffer.
// The stat_* counters exist only when BTB_STATS_EN is defined.
interface btb_if;
  logic [31:0] if_pc;
  logic        if_ihit;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_npc;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispred;
`ifdef BTB_STATS_EN
  logic [31:0] stat_lookups;
  logic [31:0] stat_hits;
  logic [31:0] stat_mispreds;
`endif

  modport slave (
`ifdef BTB_STATS_EN
    output stat_lookups, stat_hits, stat_mispreds,
`endif
    input  if_pc, if_ihit, upd_en, upd_pc, upd_taken, upd_target, upd_mispred,
    output pred_hit, pred_taken, pred_npc
  );

  modport master (
`ifdef BTB_STATS_EN
    input  stat_lookups, stat_hits, stat_mispreds,
`endif
    output if_pc, if_ihit, upd_en, upd_pc, upd_taken, upd_target, upd_mispred,
    input  pred_hit, pred_taken, pred_npc
  );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with a 2-bit saturating direction counter per entry; combinational lookup.
// Define BTB_STATS_EN to add lookup/hit/mispredict statistics counters.
module branch_target_buffer #(
  parameter int         IDXW   = 4,
  parameter logic [1:0] CNTRST = 2'b01
) (
  input logic clk_i,
  input logic rst_i,
  btb_if.slave bus
);
  localparam int ENTRIES = 2 ** IDXW;
  localparam int TAGW    = 30 - IDXW;

  logic            valid_q [ENTRIES];
  logic [TAGW-1:0] tag_q   [ENTRIES];
  logic [29:0]     tgt_q   [ENTRIES];
  logic [1:0]      cnt_q   [ENTRIES];

  logic [IDXW-1:0] lk_idx;
  logic [TAGW-1:0] lk_tag;
  logic            lk_hit;
  logic            lk_taken;

  logic [IDXW-1:0] upd_idx;
  logic [TAGW-1:0] upd_tag;
  logic            upd_hit;
  logic            wr_en;
  logic            valid_d;
  logic [TAGW-1:0] tag_d;
  logic [29:0]     tgt_d;
  logic [1:0]      cnt_d;

  // Lookup reads only registered state, so a same-cycle update is seen next cycle.
  assign lk_idx   = bus.if_pc[IDXW+1:2];
  assign lk_tag   = bus.if_pc[31:IDXW+2];
  assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_taken = lk_hit && cnt_q[lk_idx][1];

  assign bus.pred_hit   = lk_hit;
  assign bus.pred_taken = lk_taken;
  assign bus.pred_npc   = lk_taken ? {tgt_q[lk_idx], 2'b00} : (bus.if_pc + 32'd4);

  assign upd_idx = bus.upd_pc[IDXW+1:2];
  assign upd_tag = bus.upd_pc[31:IDXW+2];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  always_comb begin
    wr_en   = 1'b0;
    valid_d = valid_q[upd_idx];
    tag_d   = tag_q[upd_idx];
    tgt_d   = tgt_q[upd_idx];
    cnt_d   = cnt_q[upd_idx];
    if (bus.upd_en) begin
      if (upd_hit) begin
        wr_en = 1'b1;
        if (bus.upd_taken) begin
          cnt_d = (cnt_q[upd_idx] == 2'b11) ? 2'b11 : cnt_q[upd_idx] + 2'd1;
          tgt_d = bus.upd_target[31:2];
        end else begin
          cnt_d = (cnt_q[upd_idx] == 2'b00) ? 2'b00 : cnt_q[upd_idx] - 2'd1;
        end
      end else if (bus.upd_taken) begin
        // Allocation evicts whatever aliased into this slot.
        wr_en   = 1'b1;
        valid_d = 1'b1;
        tag_d   = upd_tag;
        tgt_d   = bus.upd_target[31:2];
        cnt_d   = 2'b10;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= CNTRST;
      end
    end else if (wr_en) begin
      valid_q[upd_idx] <= valid_d;
      tag_q[upd_idx]   <= tag_d;
      tgt_q[upd_idx]   <= tgt_d;
      cnt_q[upd_idx]   <= cnt_d;
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] lookups_q, hits_q, mispreds_q;
  logic [31:0] lookups_d, hits_d, mispreds_d;

  always_comb begin
    lookups_d  = lookups_q  + {31'd0, bus.if_ihit};
    hits_d     = hits_q     + {31'd0, bus.if_ihit && lk_hit};
    mispreds_d = mispreds_q + {31'd0, bus.upd_en && bus.upd_mispred};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lookups_q  <= 32'd0;
      hits_q     <= 32'd0;
      mispreds_q <= 32'd0;
    end else begin
      lookups_q  <= lookups_d;
      hits_q     <= hits_d;
      mispreds_q <= mispreds_d;
    end
  end

  assign bus.stat_lookups  = lookups_q;
  assign bus.stat_hits     = hits_q;
  assign bus.stat_mispreds = mispreds_q;
`endif

  // Byte-offset bits are ignored; ihit/mispred feed only the optional statistics.
  logic unused_inputs;
  assign unused_inputs = ^{bus.if_pc[1:0], bus.upd_pc[1:0], bus.upd_target[1:0],
                           bus.if_ihit, bus.upd_mispred};
endmodule
